// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage feeding the 4-entry register file write port; MUL is an iterative shift-add.
// Optional write-port operand forwarding is enabled by defining ALU_WB_FORWARD_EN.
module alu_writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 2,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [ADDR_W-1:0] dest_reg,
    input  logic              wb_en,
    output logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W-1:0] WriteReg,
    output logic              RegWrite,
    output logic              ovf,
    output logic              busy
);

    localparam int MUL_BITS = DATA_W / MUL_CYCLES;
    localparam int SH_W     = $clog2(DATA_W);
    localparam int CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] wreg_q;
    logic              regwrite_q;
    logic              ovf_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mul_dest_q;
    logic              mul_wb_q;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] pp [MUL_BITS];

`ifdef ALU_WB_FORWARD_EN
    // The register file still returns the old value while it is being written.
    assign op_a = (regwrite_q && (wreg_q == rs_a)) ? wdata_q : src_a;
    assign op_b = (regwrite_q && (wreg_q == rs_b)) ? wdata_q : src_b;
`else
    logic unused_rs;
    assign unused_rs = ^{rs_a, rs_b};
    assign op_a      = src_a;
    assign op_b      = src_b;
`endif

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res = op_a + op_b;
                alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL:  alu_res = op_a << op_b[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // One MUL iteration: partial products of the low MUL_BITS multiplier bits.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        for (int j = 0; j < MUL_BITS; j++) begin
            acc_d = acc_d + pp[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wdata_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            ovf_q      <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_dest_q <= '0;
            mul_wb_q   <= 1'b0;
        end else begin
            regwrite_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (alu_op == OP_MUL) begin
                            state_q    <= S_MUL;
                            mcand_q    <= op_a;
                            mplier_q   <= op_b;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            mul_dest_q <= dest_reg;
                            mul_wb_q   <= wb_en;
                            ovf_q      <= 1'b0;
                        end else begin
                            wdata_q    <= alu_res;
                            wreg_q     <= dest_reg;
                            regwrite_q <= wb_en;
                            ovf_q      <= alu_ovf;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << MUL_BITS;
                    mplier_q <= mplier_q >> MUL_BITS;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= S_IDLE;
                        wdata_q    <= acc_d;
                        wreg_q     <= mul_dest_q;
                        regwrite_q <= mul_wb_q;
                        ovf_q      <= 1'b0;
                        acc_q      <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_MUL);
    assign WriteData = wdata_q;
    assign WriteReg  = wreg_q;
    assign RegWrite  = regwrite_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: a per-cycle reference model plus literal checkpoints.
// Build with ALU_WB_FORWARD_EN defined to exercise the forwarding variant.
module tb_alu_writeback_stage;

    localparam int MUL_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [1:0]  rs_a = 2'd0;
    logic [1:0]  rs_b = 2'd0;
    logic [1:0]  dest_reg = 2'd0;
    logic        wb_en = 1'b0;
    logic [31:0] WriteData;
    logic [1:0]  WriteReg;
    logic        RegWrite;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    alu_writeback_stage #(.DATA_W(32), .ADDR_W(2), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .rs_a(rs_a), .rs_b(rs_b),
        .dest_reg(dest_reg), .wb_en(wb_en), .WriteData(WriteData), .WriteReg(WriteReg),
        .RegWrite(RegWrite), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Reference model: architectural view of the stage (results, pending multiply countdown).
    logic [31:0] m_wd, m_prod;
    logic [1:0]  m_wr, m_dest;
    logic        m_rw, m_ovf, m_wb;
    int          m_left;

    always @(posedge clk or negedge reset) begin : model
        logic [31:0] a, b, r;
        longint      s;
        if (!reset) begin
            m_wd <= '0; m_wr <= '0; m_rw <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
            m_prod <= '0; m_dest <= '0; m_wb <= 1'b0;
        end else begin
            m_rw <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_wd <= m_prod; m_wr <= m_dest; m_rw <= m_wb; m_ovf <= 1'b0;
                end
            end else if (in_valid) begin
                a = src_a;
                b = src_b;
`ifdef ALU_WB_FORWARD_EN
                if (m_rw && m_wr == rs_a) a = m_wd;
                if (m_rw && m_wr == rs_b) b = m_wd;
`endif
                if (alu_op == 3'd7) begin
                    m_left <= MUL_CYCLES;
                    m_prod <= a * b;
                    m_dest <= dest_reg;
                    m_wb   <= wb_en;
                    m_ovf  <= 1'b0;
                end else begin
                    s = 0;
                    r = 32'd0;
                    case (alu_op)
                        3'd0: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); end
                        3'd1: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); end
                        3'd2: r = a & b;
                        3'd3: r = a | b;
                        3'd4: r = a ^ b;
                        3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: r = a << b[4:0];
                    endcase
                    m_wd  <= r;
                    m_wr  <= dest_reg;
                    m_rw  <= wb_en;
                    // Overflow: the exact sum/difference is not what the wrapped result encodes.
                    m_ovf <= (alu_op <= 3'd1) && (s != longint'($signed(r)));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_in_ready",  {31'd0, in_ready}, {31'd0, m_left == 0});
            chk("cmp_busy",      {31'd0, busy},     {31'd0, m_left != 0});
            chk("cmp_RegWrite",  {31'd0, RegWrite}, {31'd0, m_rw});
            chk("cmp_WriteData", WriteData,         m_wd);
            chk("cmp_WriteReg",  {30'd0, WriteReg}, {30'd0, m_wr});
            chk("cmp_ovf",       {31'd0, ovf},      {31'd0, m_ovf});
        end
    end

    // Starts at a falling edge, presents one instruction, returns at the next falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] d,
                         input logic wb);
        #1;
        alu_op = op; src_a = a; src_b = b; rs_a = ra; rs_b = rb; dest_reg = d; wb_en = wb;
        in_valid = 1'b1;
        $display("txn t=%0t op=%0d a=%h b=%h rs_a=%0d rs_b=%0d dest=%0d wb=%0b",
                 $time, op, a, b, ra, rb, d, wb);
        @(negedge clk);
    endtask

    task automatic idle();
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset held with an instruction offered: nothing may be accepted.
        #1;
        reset = 1'b0;
        alu_op = 3'd0; src_a = 32'd1; src_b = 32'd1; dest_reg = 2'd1; wb_en = 1'b1;
        in_valid = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_WriteData", WriteData, 32'd0);
        chk("rst_WriteReg", {30'd0, WriteReg}, 32'd0);
        chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_RegWrite", {31'd0, RegWrite}, 32'd0);

        issue(3'd0, 32'hAAAA_FFFF, 32'h0000_0001, 2'd0, 2'd0, 2'd2, 1'b1);
        chk("add_WriteData", WriteData, 32'hAAAB_0000);
        chk("add_WriteReg", {30'd0, WriteReg}, 32'd2);
        chk("add_RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("add_ovf", {31'd0, ovf}, 32'd0);
        issue(3'd0, 32'hAAAA_FFFF, 32'h0000_0001, 2'd0, 2'd0, 2'd2, 1'b0);
        chk("add_nowb_RegWrite", {31'd0, RegWrite}, 32'd0);
        idle();
        chk("idle_RegWrite", {31'd0, RegWrite}, 32'd0);

        issue(3'd1, 32'h8000_0000, 32'h0000_0001, 2'd0, 2'd0, 2'd0, 1'b1);
        chk("sub_WriteData", WriteData, 32'h7FFF_FFFF);
        chk("sub_ovf", {31'd0, ovf}, 32'd1);
        issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd3, 2'd3, 2'd1, 1'b1);
        chk("and_WriteData", WriteData, 32'hF000_F000);
        chk("and_ovf", {31'd0, ovf}, 32'd0);
        issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 2'd2, 2'd2, 2'd2, 1'b1);
        chk("addovf_ovf", {31'd0, ovf}, 32'd1);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 2'd0, 2'd0, 1'b1);
        chk("slt_WriteData", WriteData, 32'd1);
        issue(3'd6, 32'h0000_0001, 32'h0000_0023, 2'd1, 2'd1, 2'd3, 1'b1);
        chk("sll_WriteData", WriteData, 32'd8);
        issue(3'd3, 32'h1234_0000, 32'h0000_5678, 2'd0, 2'd0, 2'd1, 1'b1);
        issue(3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'd2, 2'd2, 2'd2, 1'b1);
        idle();

        // MUL with an ADD held behind it.
        issue(3'd7, 32'h0001_0003, 32'h0000_0005, 2'd0, 2'd0, 2'd3, 1'b1);
        chk("mul_busy_1", {31'd0, busy}, 32'd1);
        chk("mul_ready_1", {31'd0, in_ready}, 32'd0);
        #1;
        alu_op = 3'd0; src_a = 32'h10; src_b = 32'h20; rs_a = 2'd0; rs_b = 2'd0;
        dest_reg = 2'd1; wb_en = 1'b1; in_valid = 1'b1;
        $display("txn t=%0t op=0 a=%h b=%h held behind MUL", $time, src_a, src_b);
        for (int i = 0; i < MUL_CYCLES - 1; i++) begin
            @(negedge clk);
            chk("mul_busy_n", {31'd0, busy}, 32'd1);
            chk("mul_ready_n", {31'd0, in_ready}, 32'd0);
            chk("mul_norw_n", {31'd0, RegWrite}, 32'd0);
        end
        @(negedge clk);
        chk("mul_WriteData", WriteData, 32'h0005_000F);
        chk("mul_WriteReg", {30'd0, WriteReg}, 32'd3);
        chk("mul_RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("mul_done_busy", {31'd0, busy}, 32'd0);
        chk("mul_done_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("held_add_WriteData", WriteData, 32'h30);
        chk("held_add_RegWrite", {31'd0, RegWrite}, 32'd1);
        idle();

        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 2'd2, 1'b0);
        #1 in_valid = 1'b0;
        repeat (MUL_CYCLES) @(negedge clk);
        chk("mul2_WriteData", WriteData, 32'd1);
        chk("mul2_RegWrite", {31'd0, RegWrite}, 32'd0);

        // Dependent back-to-back pair: second ADD reads register 1 stale.
        issue(3'd0, 32'd5, 32'd0, 2'd0, 2'd0, 2'd1, 1'b1);
        chk("fwd_first", WriteData, 32'd5);
        issue(3'd0, 32'd0, 32'd1, 2'd1, 2'd2, 2'd2, 1'b1);
`ifdef ALU_WB_FORWARD_EN
        chk("fwd_second", WriteData, 32'd6);
`else
        chk("fwd_second", WriteData, 32'd1);
`endif
        idle();

        // Reset during the second MUL cycle aborts the multiply.
        issue(3'd7, 32'd7, 32'd9, 2'd0, 2'd0, 2'd1, 1'b1);
        #1 in_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_RegWrite", {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_after_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("abort_after_WriteData", WriteData, 32'd0);
        issue(3'd0, 32'd1, 32'd1, 2'd0, 2'd0, 2'd2, 1'b1);
        chk("post_add_WriteData", WriteData, 32'd2);
        chk("post_add_RegWrite", {31'd0, RegWrite}, 32'd1);
        idle();
        idle();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
